// File: rtl/calc_token_sequencer_if.sv
// Token handshake between the ROM fetch sequencer (master) and the expression evaluator (slave).
interface calc_token_sequencer_if #(
    parameter int OPND_W = 16
);
    logic              tok_valid;
    logic              tok_ready;
    logic [1:0]        tok_kind;
    logic [OPND_W-1:0] tok_operand;
    logic [1:0]        tok_op;

    modport master (
        output tok_valid,
        output tok_kind,
        output tok_operand,
        output tok_op,
        input  tok_ready
    );

    modport slave (
        input  tok_valid,
        input  tok_kind,
        input  tok_operand,
        input  tok_op,
        output tok_ready
    );
endinterface

// File: rtl/calc_token_sequencer.sv
// Walks the token ROM from address 0, folds digit runs into binary operands and
// hands operands, operator opcodes and the end marker to the evaluator.
module calc_token_sequencer #(
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 100,
    parameter int OPND_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_W-1:0]     rom_index,
    input  logic [7:0]            rom_data,
    calc_token_sequencer_if.master tok,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_W-1:0]     err_index
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_EMIT_NUM = 3'd2,
        ST_EMIT_OP  = 3'd3,
        ST_EMIT_END = 3'd4,
        ST_DONE     = 3'd5,
        ST_ERR      = 3'd6
    } state_t;

    localparam logic [1:0] KIND_OPND = 2'd0;
    localparam logic [1:0] KIND_OP   = 2'd1;
    localparam logic [1:0] KIND_END  = 2'd2;

    // Four guard bits hold acc*10+9 exactly, so overflow is a plain compare.
    localparam int                ACC_W     = OPND_W + 4;
    localparam logic [ACC_W-1:0]  ACC_MAX   = {4'd0, {OPND_W{1'b1}}};
    localparam logic [ADDR_W-1:0] PTR_LIMIT = ADDR_W'(DEPTH);

    state_t              state_r, state_nx;
    logic [ADDR_W-1:0]   ptr_r, ptr_nx;
    logic [OPND_W-1:0]   acc_r, acc_nx;
    logic                have_digit_r, have_digit_nx;
    logic                end_pend_r, end_pend_nx;
    logic [1:0]          opcode_r, opcode_nx;
    logic [ADDR_W-1:0]   err_index_r, err_index_nx;

    logic                tok_valid_r, tok_valid_nx;
    logic [1:0]          tok_kind_r, tok_kind_nx;
    logic                busy_r, busy_nx;
    logic                done_r, err_r;

    logic [ACC_W-1:0]    acc_next_s;
    logic                is_digit_s, is_end_s, is_op_s;

    function automatic logic code_is_op(input logic [7:0] code);
        return (code >= 8'd20) && (code <= 8'd23);
    endfunction

    assign is_digit_s = (rom_data <= 8'd9);
    assign is_end_s   = (rom_data == 8'd10);
    assign is_op_s    = code_is_op(rom_data);
    assign acc_next_s = ({4'd0, acc_r} * ACC_W'(10)) + ACC_W'(rom_data[3:0]);

    // Next-state, datapath updates and next values of the registered outputs.
    always_comb begin
        state_nx      = state_r;
        ptr_nx        = ptr_r;
        acc_nx        = acc_r;
        have_digit_nx = have_digit_r;
        end_pend_nx   = end_pend_r;
        opcode_nx     = opcode_r;
        err_index_nx  = err_index_r;

        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_nx      = ST_FETCH;
                    ptr_nx        = '0;
                    acc_nx        = '0;
                    have_digit_nx = 1'b0;
                    end_pend_nx   = 1'b0;
                    err_index_nx  = '0;
                end else begin
                    state_nx = state_r;
                end
            end
            ST_FETCH: begin
                if (ptr_r == PTR_LIMIT) begin
                    state_nx     = ST_ERR;
                    err_index_nx = ptr_r;
                end else if (is_digit_s) begin
                    if (acc_next_s > ACC_MAX) begin
                        state_nx     = ST_ERR;
                        err_index_nx = ptr_r;
                    end else begin
                        acc_nx        = acc_next_s[OPND_W-1:0];
                        have_digit_nx = 1'b1;
                        ptr_nx        = ptr_r + ADDR_W'(1);
                    end
                end else if ((is_end_s || is_op_s) && !have_digit_r) begin
                    state_nx     = ST_ERR;
                    err_index_nx = ptr_r;
                end else if (is_end_s) begin
                    end_pend_nx = 1'b1;
                    state_nx    = ST_EMIT_NUM;
                end else if (is_op_s) begin
                    opcode_nx = rom_data[1:0];
                    state_nx  = ST_EMIT_NUM;
                end else begin
                    state_nx     = ST_ERR;
                    err_index_nx = ptr_r;
                end
            end
            ST_EMIT_NUM: begin
                if (tok.tok_ready) begin
                    acc_nx        = '0;
                    have_digit_nx = 1'b0;
                    state_nx      = end_pend_r ? ST_EMIT_END : ST_EMIT_OP;
                end else begin
                    state_nx = state_r;
                end
            end
            ST_EMIT_OP: begin
                if (tok.tok_ready) begin
                    ptr_nx   = ptr_r + ADDR_W'(1);
                    state_nx = ST_FETCH;
                end else begin
                    state_nx = state_r;
                end
            end
            ST_EMIT_END: begin
                if (tok.tok_ready) begin
                    state_nx = ST_DONE;
                end else begin
                    state_nx = state_r;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        case (state_nx)
            ST_EMIT_NUM: begin
                tok_valid_nx = 1'b1;
                tok_kind_nx  = KIND_OPND;
            end
            ST_EMIT_OP: begin
                tok_valid_nx = 1'b1;
                tok_kind_nx  = KIND_OP;
            end
            ST_EMIT_END: begin
                tok_valid_nx = 1'b1;
                tok_kind_nx  = KIND_END;
            end
            default: begin
                tok_valid_nx = 1'b0;
                tok_kind_nx  = KIND_OPND;
            end
        endcase

        busy_nx = !((state_nx == ST_IDLE) || (state_nx == ST_DONE) || (state_nx == ST_ERR));
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            ptr_r        <= '0;
            acc_r        <= '0;
            have_digit_r <= 1'b0;
            end_pend_r   <= 1'b0;
            opcode_r     <= 2'd0;
            err_index_r  <= '0;
        end else begin
            state_r      <= state_nx;
            ptr_r        <= ptr_nx;
            acc_r        <= acc_nx;
            have_digit_r <= have_digit_nx;
            end_pend_r   <= end_pend_nx;
            opcode_r     <= opcode_nx;
            err_index_r  <= err_index_nx;
        end
    end

    // Status and handshake outputs registered from the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_valid_r <= 1'b0;
            tok_kind_r  <= KIND_OPND;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            tok_valid_r <= tok_valid_nx;
            tok_kind_r  <= tok_kind_nx;
            busy_r      <= busy_nx;
            done_r      <= (state_nx == ST_DONE);
            err_r       <= (state_nx == ST_ERR);
        end
    end

    assign rom_index       = ptr_r;
    assign err_index       = err_index_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign err             = err_r;
    assign tok.tok_valid   = tok_valid_r;
    assign tok.tok_kind    = tok_kind_r;
    assign tok.tok_operand = acc_r;
    assign tok.tok_op      = opcode_r;

endmodule
